wb_regfile_irq: RTL and testbench

Parametrised Wishbone classic slave register bank with configurable wait states, byte-lane writes and a write-1-to-clear interrupt status/enable pair. It supersedes the fixed five-bit-address demo register slave on the PicoRV32 external Wishbone port. It drives a registered level interrupt back into the CPU `irq_in` vector and exposes its general-purpose registers to fabric logic.

---
 rtl/wb_regfile_irq_if.sv | 28 ++
 rtl/wb_regfile_irq.sv | 119 +++++++++++
 tb/tb_wb_regfile_irq.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_irq_if.sv
// wb_regfile_irq_if: Wishbone classic bus bundle between a CPU-side master and the register bank.
// Signal names keep the slave's point of view:
//   adr_i  byte address          dat_i  write data       sel_i  byte-lane select
//   we_i   1 = write, 0 = read   stb_i  strobe           cyc_i  cycle
//   dat_o  registered read data  ack_o  one-cycle acknowledge
interface wb_regfile_irq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0]   adr_i;
    logic [DATA_W-1:0]   dat_i;
    logic [DATA_W-1:0]   dat_o;
    logic [DATA_W/8-1:0] sel_i;
    logic                we_i;
    logic                stb_i;
    logic                cyc_i;
    logic                ack_o;

    modport master (
        output adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  adr_i, dat_i, sel_i, we_i, stb_i, cyc_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/wb_regfile_irq.sv
// wb_regfile_irq: Wishbone classic register bank with wait states, byte-lane writes and a W1C interrupt pair.
// Ports:
//   clk_i      single clock
//   rst_i      synchronous active-high reset
//   wb         Wishbone slave bundle (adr/dat/sel/we/stb/cyc in, dat/ack out)
//   irq_evt_i  per-bit interrupt event pulses, sampled every cycle
//   irq_o      registered level interrupt, |(IRQ_STATUS & IRQ_ENABLE)
//   reg_o      general registers flattened, reg 0 in the LSBs
// Word map: 0..NUM_REGS-3 general, NUM_REGS-2 IRQ_STATUS (W1C), NUM_REGS-1 IRQ_ENABLE.
module wb_regfile_irq #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int WAIT_STATES = 0
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    wb_regfile_irq_if.slave                     wb,
    input  logic [DATA_W-1:0]                   irq_evt_i,
    output logic                                irq_o,
    output logic [(2**(ADDR_W-2)-2)*DATA_W-1:0] reg_o
);
    localparam int NUM_REGS = 2 ** (ADDR_W - 2);
    localparam int IW       = ADDR_W - 2;
    localparam int SW       = DATA_W / 8;
    localparam int ST       = NUM_REGS - 2;
    localparam int EN       = NUM_REGS - 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IW-1:0]     adr_q, adr_d;
    logic [DATA_W-1:0] dat_q, dat_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              we_q, we_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              req;
    logic              cap;
    logic              commit;
    logic              wr;
    logic [DATA_W-1:0] lane;
    logic              unused_adr;

    assign req        = wb.cyc_i & wb.stb_i;
    assign unused_adr = ^wb.adr_i[1:0];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdat_q  <= '0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdat_q  <= rdat_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
        end
    end

    // A dropped strobe in WAIT abandons the transfer before anything commits.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                state_d = req ? (WAIT_STATES > 0 ? S_WAIT : S_ACK) : S_IDLE;
                cnt_d   = req ? 4'(WAIT_STATES) : cnt_q;
            end
            S_WAIT: begin
                state_d = !req ? S_IDLE : cnt_q == 4'd1 ? S_ACK : S_WAIT;
                cnt_d   = req && cnt_q != 4'd1 ? cnt_q - 4'd1 : cnt_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // The *_d capture values equal the live bus in IDLE and the held request
    // in WAIT, so they are the right operands for a commit from either state.
    always_comb begin
        cap    = state_q == S_IDLE && req;
        commit = state_d == S_ACK && state_q != S_ACK;
        adr_d  = cap ? wb.adr_i[ADDR_W-1:2] : adr_q;
        dat_d  = cap ? wb.dat_i : dat_q;
        sel_d  = cap ? wb.sel_i : sel_q;
        we_d   = cap ? wb.we_i : we_q;
        wr     = commit && we_d;
        lane   = '0;
        for (int b = 0; b < SW; b++) lane[8*b +: 8] = {8{sel_d[b]}};
        // Status ORs in events after the clear so a same-edge event wins.
        for (int i = 0; i < NUM_REGS; i++)
            regs_d[i] = i == ST
                ? (regs_q[i] & ~(wr && adr_d == IW'(i) ? dat_d & lane : '0)) | irq_evt_i
                : wr && adr_d == IW'(i) ? (regs_q[i] & ~lane) | (dat_d & lane) : regs_q[i];
        rdat_d = commit && !we_d ? regs_q[adr_d] : '0;
        irq_d  = |(regs_q[ST] & regs_q[EN]);
    end

    assign wb.ack_o = state_q == S_ACK;
    assign wb.dat_o = rdat_q;
    assign irq_o    = irq_q;

    for (genvar g = 0; g < NUM_REGS - 2; g++) begin : g_reg
        assign reg_o[g*DATA_W +: DATA_W] = regs_q[g];
    end
endmodule

// File: tb/tb_wb_regfile_irq.sv
// tb_wb_regfile_irq: directed bench for wb_regfile_irq with a zero-wait and a three-wait instance.
module tb_wb_regfile_irq;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [4:0]   adr = '0;
    logic [31:0]  dat = '0;
    logic [3:0]   sel = '0;
    logic         we = 1'b0;
    logic         stb = 1'b0;
    logic         cyc = 1'b0;
    logic [31:0]  evt = '0;
    logic         dsel = 1'b0;
    logic [31:0]  evt0, evt3;
    logic         irq0, irq3, ack, irq;
    logic [31:0]  rdat;
    logic [191:0] rego0, rego3, rego;
    int           checks = 0;
    int           failures = 0;

    always #5 clk = ~clk;

    wb_regfile_irq_if #(.DATA_W(32), .ADDR_W(5)) b0 ();
    wb_regfile_irq_if #(.DATA_W(32), .ADDR_W(5)) b3 ();

    assign b0.adr_i = adr;
    assign b0.dat_i = dat;
    assign b0.sel_i = sel;
    assign b0.we_i  = we;
    assign b0.cyc_i = cyc & ~dsel;
    assign b0.stb_i = stb & ~dsel;
    assign b3.adr_i = adr;
    assign b3.dat_i = dat;
    assign b3.sel_i = sel;
    assign b3.we_i  = we;
    assign b3.cyc_i = cyc & dsel;
    assign b3.stb_i = stb & dsel;
    assign evt0     = dsel ? 32'h0 : evt;
    assign evt3     = dsel ? evt : 32'h0;
    assign ack      = dsel ? b3.ack_o : b0.ack_o;
    assign rdat     = dsel ? b3.dat_o : b0.dat_o;
    assign irq      = dsel ? irq3 : irq0;
    assign rego     = dsel ? rego3 : rego0;

    wb_regfile_irq #(.DATA_W(32), .ADDR_W(5), .WAIT_STATES(0)) u0 (
        .clk_i(clk), .rst_i(rst), .wb(b0.slave), .irq_evt_i(evt0), .irq_o(irq0), .reg_o(rego0)
    );
    wb_regfile_irq #(.DATA_W(32), .ADDR_W(5), .WAIT_STATES(3)) u3 (
        .clk_i(clk), .rst_i(rst), .wb(b3.slave), .irq_evt_i(evt3), .irq_o(irq3), .reg_o(rego3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts at a negedge; latency counts edges from the sampling edge to the ack cycle.
    task automatic xfer(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] ev, output logic [31:0] rd, output logic irq_ack,
                        output logic [191:0] rego_ack);
        int lat;
        lat = -1;
        rd = '0;
        irq_ack = 1'b0;
        rego_ack = '0;
        adr = a; dat = d; sel = s; we = w; cyc = 1'b1; stb = 1'b1; evt = ev;
        for (int i = 1; i <= 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            evt = '0;
            if (ack) begin
                lat = i;
                break;
            end
        end
        rd = rdat;
        irq_ack = irq;
        rego_ack = rego;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        chk("ack_latency", lat, dsel ? 4 : 1);
        @(negedge clk);
        chk("ack_pulse", ack, 0);
        chk("dat_idle", rdat, 0);
    endtask

    task automatic abort_xfer(input logic w, input logic [4:0] a, input logic [31:0] d);
        int acks;
        acks = 0;
        adr = a; dat = d; sel = 4'hF; we = w; cyc = 1'b1; stb = 1'b1;
        repeat (2) @(negedge clk);
        stb = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acks += int'(ack);
        end
        cyc = 1'b0; we = 1'b0;
        chk("abort_no_ack", acks, 0);
        chk("abort_idle", u3.state_q, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]  rd;
        logic         ia;
        logic [191:0] ra;
        int           acks;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_irq", irq, 0);
        chk("rst_rego", |rego, 0);
        for (int i = 0; i < 8; i++) begin
            xfer(1'b0, 5'(i * 4), 32'h0, 4'hF, 32'h0, rd, ia, ra);
            chk("rd_after_rst", rd, 0);
            chk("irq_after_rst", irq, 0);
        end
        xfer(1'b1, 5'h04, 32'hDEADBEEF, 4'b0101, 32'h0, rd, ia, ra);
        chk("rego_at_ack", ra[63:32], 32'h00AD00EF);
        chk("rego_after", rego[63:32], 32'h00AD00EF);
        xfer(1'b0, 5'h06, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("rd_lane_mask", rd, 32'h00AD00EF);
        xfer(1'b1, 5'h04, 32'h11223344, 4'hF, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h04, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("rd_full", rd, 32'h11223344);
        chk("rego_reg0", rego[31:0], 32'h0);
        xfer(1'b1, 5'h1C, 32'h1, 4'hF, 32'h0, rd, ia, ra);
        evt = 32'h3;
        @(negedge clk);
        evt = '0;
        chk("irq_edge_k", irq, 0);
        @(negedge clk);
        chk("irq_edge_k1", irq, 1);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_set", rd, 32'h3);
        xfer(1'b1, 5'h18, 32'h1, 4'hF, 32'h0, rd, ia, ra);
        chk("irq_at_w1c_ack", ia, 1);
        chk("irq_after_w1c", irq, 0);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_w1c", rd, 32'h2);
        xfer(1'b1, 5'h18, 32'h2, 4'hF, 32'h2, rd, ia, ra);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_collision", rd, 32'h2);
        xfer(1'b1, 5'h18, 32'h2, 4'hF, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_cleared", rd, 32'h0);
        xfer(1'b1, 5'h18, 32'hFFFFFFFF, 4'hF, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_no_sw_set", rd, 32'h0);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h00000300, rd, ia, ra);
        chk("status_read_before_evt", rd, 32'h0);
        xfer(1'b1, 5'h18, 32'h00000300, 4'b0001, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_lane_unsel", rd, 32'h00000300);
        xfer(1'b1, 5'h18, 32'h00000300, 4'b0010, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h18, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("status_lane_sel", rd, 32'h0);
        xfer(1'b0, 5'h1C, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("enable_rd", rd, 32'h1);

        dsel = 1'b1;
        @(negedge clk);
        xfer(1'b0, 5'h00, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("ws3_rd0", rd, 32'h0);
        abort_xfer(1'b0, 5'h00, 32'h0);
        abort_xfer(1'b1, 5'h00, 32'hA5A5A5A5);
        chk("abort_no_write", rego[31:0], 32'h0);
        xfer(1'b0, 5'h00, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("ws3_rd_after_abort", rd, 32'h0);
        xfer(1'b1, 5'h08, 32'hCAFEF00D, 4'hF, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h08, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("ws3_rd_reg2", rd, 32'hCAFEF00D);
        xfer(1'b1, 5'h1C, 32'hFFFFFFFF, 4'hF, 32'h0, rd, ia, ra);
        evt = 32'h1;
        @(negedge clk);
        evt = '0;
        @(negedge clk);
        chk("ws3_irq", irq, 1);
        adr = 5'h00; dat = 32'h12345678; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            acks += int'(ack);
        end
        chk("rst_wait_no_ack", acks, 0);
        chk("rst_wait_rego", |rego, 0);
        chk("rst_wait_irq", irq, 0);
        xfer(1'b0, 5'h08, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("rst_wait_reg2", rd, 32'h0);
        xfer(1'b0, 5'h1C, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("rst_wait_enable", rd, 32'h0);
        xfer(1'b1, 5'h00, 32'h12345678, 4'hF, 32'h0, rd, ia, ra);
        xfer(1'b0, 5'h00, 32'h0, 4'hF, 32'h0, rd, ia, ra);
        chk("post_rst_xfer", rd, 32'h12345678);
        chk("post_rst_rego", rego[31:0], 32'h12345678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
